// File: rtl/wdt_cfg_sync_rx.sv
// wdt_cfg_sync_rx: clk2-side receiver for watchdog config writes sent over
// a toggle req/ack handshake from the bus clock domain.
//
// Ports:
//   clk2, rst2 (async, active-high)     timer-domain clock and reset
//   req_tgl                             request toggle, asynchronous to clk2
//   wr_sel[1:0], wr_data[31:0]          quasi-static write select and data
//   WDEN_clk2, WDLIVE_clk2, WTOCNT_clk2 watchdog timer controls
//   ack_tgl, ack_err                    ack toggle and status of last request
//
// Build option: define WDT_SYNC3_EN for a three-stage request synchronizer.
module wdt_cfg_sync_rx #(
  parameter logic [31:0] WTOCNT_RST = 32'hFFFF_FFFF
) (
  input  logic        clk2,
  input  logic        rst2,
  input  logic        req_tgl,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic        WDEN_clk2,
  output logic        WDLIVE_clk2,
  output logic [31:0] WTOCNT_clk2,
  output logic        ack_tgl,
  output logic        ack_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e      state_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        req_sync;
  logic        req_seen_q;
  logic [1:0]  sel_h_q;
  logic [31:0] data_h_q;
  logic        err_q;
  logic        err_d;
  logic        pending;

  logic        wden_q;
  logic        wdlive_q;
  logic [31:0] wtocnt_q;
  logic        ack_tgl_q;
  logic        ack_err_q;

`ifdef WDT_SYNC3_EN
  logic sync3_q;

  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      sync3_q <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
    end
  end

  assign req_sync = sync3_q;
`else
  assign req_sync = sync2_q;
`endif

  // Plain flop chain; nothing sits between the stages.
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= req_tgl;
      sync2_q <= sync1_q;
    end
  end

  assign pending = req_sync ^ req_seen_q;

  // A WTOCNT write is refused while the watchdog is running.
  always_comb begin
    err_d = 1'b0;
    unique case (sel_h_q)
      2'd0: err_d = 1'b0;
      2'd1: err_d = 1'b0;
      2'd2: err_d = wden_q;
      2'd3: err_d = 1'b1;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      sel_h_q    <= 2'd0;
      data_h_q   <= 32'd0;
      err_q      <= 1'b0;
      wden_q     <= 1'b0;
      wdlive_q   <= 1'b0;
      wtocnt_q   <= WTOCNT_RST;
      ack_tgl_q  <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pending) begin
            sel_h_q  <= wr_sel;
            data_h_q <= wr_data;
            state_q  <= APPLY;
          end
        end
        APPLY: begin
          err_q <= err_d;
          unique case (sel_h_q)
            2'd0: wden_q <= data_h_q[0];
            2'd1: wdlive_q <= data_h_q[0];
            2'd2: begin
              if (!wden_q) begin
                wtocnt_q <= data_h_q;
              end
            end
            default: ;
          endcase
          state_q <= ACK;
        end
        ACK: begin
          ack_tgl_q  <= ~ack_tgl_q;
          ack_err_q  <= err_q;
          req_seen_q <= ~req_seen_q;
          wdlive_q   <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign WDEN_clk2   = wden_q;
  assign WDLIVE_clk2 = wdlive_q;
  assign WTOCNT_clk2 = wtocnt_q;
  assign ack_tgl     = ack_tgl_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_wdt_cfg_sync_rx.sv
// tb_wdt_cfg_sync_rx: scoreboard bench for wdt_cfg_sync_rx.
// Expected ack status and register values are queued per request.
module tb_wdt_cfg_sync_rx;

`ifdef WDT_SYNC3_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk2 = 1'b0;
  logic        rst2 = 1'b1;
  logic        req_tgl = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        WDEN_clk2;
  logic        WDLIVE_clk2;
  logic [31:0] WTOCNT_clk2;
  logic        ack_tgl;
  logic        ack_err;

  wdt_cfg_sync_rx dut (
    .clk2        (clk2),
    .rst2        (rst2),
    .req_tgl     (req_tgl),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .WDEN_clk2   (WDEN_clk2),
    .WDLIVE_clk2 (WDLIVE_clk2),
    .WTOCNT_clk2 (WTOCNT_clk2),
    .ack_tgl     (ack_tgl),
    .ack_err     (ack_err)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic        err;
    logic        wden;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  logic        ack_prev = 1'b0;
  logic        m_wden = 1'b0;
  logic [31:0] m_cnt = 32'hFFFF_FFFF;

  // Scoreboard: every ack toggle pops one expectation.
  always @(posedge clk2) begin
    exp_t e;
    #1;
    if (rst2) begin
      ack_prev = ack_tgl;
    end else if (ack_tgl !== ack_prev) begin
      ack_prev = ack_tgl;
      ack_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack ack_tgl=%0b at %0t", ack_tgl, $time);
      end else begin
        e = q.pop_front();
        if ({ack_err, WDEN_clk2, WTOCNT_clk2} !== {e.err, e.wden, e.cnt}) begin
          errors++;
          $display("FAIL ack_result got err=%0b wden=%0b cnt=%h exp err=%0b wden=%0b cnt=%h",
                   ack_err, WDEN_clk2, WTOCNT_clk2, e.err, e.wden, e.cnt);
        end
      end
    end
  end

  // Updates the reference model, queues the expectation, toggles the request.
  task automatic issue(input logic [1:0] sel, input logic [31:0] data);
    exp_t e;
    e.err = 1'b0;
    case (sel)
      2'd0: m_wden = data[0];
      2'd2: begin
        if (!m_wden) m_cnt = data;
        else e.err = 1'b1;
      end
      2'd3: e.err = 1'b1;
      default: ;
    endcase
    e.wden = m_wden;
    e.cnt  = m_cnt;
    q.push_back(e);
    @(negedge clk2);
    wr_sel  = sel;
    wr_data = data;
    req_tgl = ~req_tgl;
  endtask

  task automatic wait_acks(input int target, input string name);
    int n = 0;
    while (ack_cnt < target && n < 40) begin
      @(negedge clk2);
      n++;
    end
    checks++;
    if (ack_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout acks=%0d exp=%0d", name, ack_cnt, target);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk2);
    checks++;
    if ({WDEN_clk2, WDLIVE_clk2, WTOCNT_clk2, ack_tgl, ack_err} !==
        {1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals got en=%0b live=%0b cnt=%h ack=%0b err=%0b",
               WDEN_clk2, WDLIVE_clk2, WTOCNT_clk2, ack_tgl, ack_err);
    end
    rst2 = 1'b0;
    repeat (2) @(negedge clk2);
  endtask

  task automatic test_wtocnt;
    logic a0;
    int   base;
    base = ack_cnt;
    a0 = ack_tgl;
    issue(2'd2, 32'h0000_0100);
    repeat (3 + LAT) @(posedge clk2);
    #1;
    checks++;
    if (WTOCNT_clk2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wtocnt_early got=%h exp=ffffffff", WTOCNT_clk2);
    end
    @(posedge clk2);
    #1;
    checks++;
    if (WTOCNT_clk2 !== 32'h100 || ack_tgl !== a0 || WDLIVE_clk2 !== 1'b0) begin
      errors++;
      $display("FAIL wtocnt_apply got cnt=%h ack=%0b live=%0b exp cnt=100 ack=%0b live=0",
               WTOCNT_clk2, ack_tgl, WDLIVE_clk2, a0);
    end
    @(posedge clk2);
    #1;
    checks++;
    if (ack_tgl !== ~a0) begin
      errors++;
      $display("FAIL wtocnt_ack_edge got=%0b exp=%0b", ack_tgl, ~a0);
    end
    wait_acks(base + 1, "wtocnt");
  endtask

  task automatic test_wden_block;
    int base;
    base = ack_cnt;
    issue(2'd0, 32'h1);
    wait_acks(base + 1, "wden_set");
    issue(2'd2, 32'h50);
    wait_acks(base + 2, "wtocnt_blocked");
    checks++;
    if (WTOCNT_clk2 !== 32'h100 || WDEN_clk2 !== 1'b1) begin
      errors++;
      $display("FAIL wden_block got cnt=%h en=%0b exp cnt=100 en=1",
               WTOCNT_clk2, WDEN_clk2);
    end
  endtask

  task automatic test_wdlive;
    logic [31:0] d;
    int          hi;
    int          base;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 32'h1 : 32'h0;
      base = ack_cnt;
      hi = 0;
      issue(2'd1, d);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk2);
        #1;
        if (WDLIVE_clk2 === 1'b1) hi++;
      end
      wait_acks(base + 1, "wdlive");
      checks++;
      if (hi !== ((k == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL wdlive_pulse data=%0d got=%0d exp=%0d",
                 d[0], hi, (k == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reserved;
    int base;
    base = ack_cnt;
    issue(2'd3, 32'hFFFF_FFFF);
    wait_acks(base + 1, "reserved");
    issue(2'd0, 32'h0);
    wait_acks(base + 2, "wden_clr");
    checks++;
    if (WDEN_clk2 !== 1'b0 || ack_err !== 1'b0) begin
      errors++;
      $display("FAIL wden_clr got en=%0b err=%0b exp en=0 err=0",
               WDEN_clk2, ack_err);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = ack_cnt;
    issue(2'd0, 32'h0);
    repeat (3 + LAT) @(posedge clk2);
    issue(2'd2, 32'h200);
    wait_acks(base + 2, "b2b");
    repeat (10) @(negedge clk2);
    checks++;
    if (ack_cnt - base !== 2 || WTOCNT_clk2 !== 32'h200) begin
      errors++;
      $display("FAIL b2b_count got acks=%0d cnt=%h exp acks=2 cnt=200",
               ack_cnt - base, WTOCNT_clk2);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    base = ack_cnt;
    issue(2'd0, 32'h1);
    repeat (3 + LAT) @(posedge clk2);
    #2;
    rst2 = 1'b1;
    req_tgl = 1'b0;
    #1;
    checks++;
    if ({WDEN_clk2, WDLIVE_clk2, WTOCNT_clk2, ack_tgl, ack_err} !==
        {1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got en=%0b live=%0b cnt=%h ack=%0b err=%0b",
               WDEN_clk2, WDLIVE_clk2, WTOCNT_clk2, ack_tgl, ack_err);
    end
    q.delete();
    m_wden = 1'b0;
    m_cnt  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk2);
    rst2 = 1'b0;
    repeat (12) @(negedge clk2);
    checks++;
    if (ack_tgl !== 1'b0 || WDEN_clk2 !== 1'b0 || ack_cnt !== base) begin
      errors++;
      $display("FAIL reset_no_ack got ack=%0b en=%0b acks=%0d exp 0 0 %0d",
               ack_tgl, WDEN_clk2, ack_cnt, base);
    end
  endtask

  initial begin
    test_reset();
    test_wtocnt();
    test_wden_block();
    test_wdlive();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expect got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdt_cfg_sync_rx.md
# wdt_cfg_sync_rx

Receiving side of the watchdog configuration path, entirely in the `clk2` domain. It accepts register writes issued from the bus (`clk`) domain over a toggle request/acknowledge handshake. It synchronizes the request and captures the held write data, then drives `WDEN_clk2`, `WDLIVE_clk2` and `WTOCNT_clk2` directly into the watchdog timer. It returns a toggle acknowledge and an error flag for the sender to synchronize back into `clk`.

## Interface
Parameters:
- `WTOCNT_RST`, default 32'hFFFF_FFFF: reset value of `WTOCNT_clk2`.

Ports:
- `clk2`  input  1  timer-domain clock.
- `rst2`  input  1  reset, asynchronous, active-high (reset rst2, asynchronous, active-high; clock clk2).
- `req_tgl`  input  1  request toggle from `clk` domain; asynchronous; each level change is one write request.
- `wr_sel`  input  2  register select: 0 = WDEN, 1 = WDLIVE, 2 = WTOCNT, 3 = reserved.
  - Quasi-static: the sender holds it stable from the `req_tgl` change until it sees `ack_tgl` change.
- `wr_data`  input  32  write data; same stability rule as `wr_sel`.
- `WDEN_clk2`  output  1  watchdog enable level.
- `WDLIVE_clk2`  output  1  one-cycle restart pulse.
- `WTOCNT_clk2`  output  32  timeout compare value.
- `ack_tgl`  output  1  acknowledge toggle; changes level once per completed request.
- `ack_err`  output  1  status of the last completed request; valid when `ack_tgl` changes, held until the next ack.

## Operation
- Synchronizer: `req_tgl` passes through a flop chain (`sync1`, `sync2`) into `req_sync`. No logic is placed between the chain stages.
- `req_seen` register: a pending event exists when `req_sync != req_seen`.
- FSM states:
  - IDLE:
    - On a pending event, load `wr_sel` and `wr_data` into hold registers `sel_h` and `data_h`.
    - Go to APPLY.
  - APPLY: update the target register from `sel_h`/`data_h` and compute `err`, then go to ACK. Per `sel_h`:
    - 0: `WDEN_clk2 <= data_h[0]`; `err = 0`.
    - 1: `WDLIVE_clk2 <= data_h[0]` (pulse); `err = 0`.
      - Writing 0 produces no pulse and no error.
    - 2: if `WDEN_clk2 == 0`, `WTOCNT_clk2 <= data_h` and `err = 0`.
      - Otherwise the write is dropped, `WTOCNT_clk2` is unchanged and `err = 1`.
    - 3: no register change; `err = 1`.
  - ACK:
    - `ack_tgl <= ~ack_tgl`; `ack_err <= err`; `req_seen <= ~req_seen`; `WDLIVE_clk2 <= 0`.
    - Go to IDLE.
- `WDLIVE_clk2` is high for exactly one `clk2` cycle, the APPLY→ACK cycle. It is 0 in all other cycles.
- `WDEN_clk2` and `WTOCNT_clk2` change only in APPLY. They hold their value otherwise.
- Protocol:
  - The sender must not toggle `req_tgl` again until it has observed the `ack_tgl` change.
  - An early toggle is not lost. If `req_sync` still differs from `req_seen` after ACK, it is serviced from IDLE as a new request, using whatever `wr_sel`/`wr_data` are present at that time.
- Events arriving while in APPLY or ACK wait until IDLE.
- `wr_sel`/`wr_data` are sampled only at the IDLE→APPLY edge. Changes outside that edge are ignored.
- Reset (`rst2` high, at any time including mid-request):
  - Returns the FSM to IDLE.
  - Clears `sync1`, `sync2`, any extra stage, and `req_seen` to 0.
  - Drives `WDEN_clk2 = 0`, `WDLIVE_clk2 = 0`, `WTOCNT_clk2 = WTOCNT_RST`, `ack_tgl = 0`, `ack_err = 0`.
  - The sender is reset to `req_tgl = 0` by `rst`. An in-flight request is discarded without an ack.

## Timing
- E0 is the first `clk2` edge that samples the new `req_tgl` level.
- Two-stage synchronizer:
  - `req_sync` updates at E1.
  - Capture at E2.
  - Register update and `WDLIVE_clk2` rise at E3.
  - `ack_tgl`/`ack_err` update and `WDLIVE_clk2` fall at E4.
- A request-to-ack latency of 4 `clk2` edges, plus 0..1 cycle of metastability uncertainty.
- Back-to-back requests: the next capture occurs at the earliest one cycle after ACK, i.e. at most one request per 3 `clk2` cycles once synchronized.

## Configuration
- `WDT_SYNC3_EN` defined:
  - The request synchronizer has three stages (`sync1`, `sync2`, `sync3`).
  - All Timing events shift by +1 edge: capture E3, apply E4, ack E5.
- Not defined: two stages, with the latencies given in Timing.
- Functional behaviour is otherwise identical.

## Test plan
- Reset: assert `rst2` mid-APPLY -> all outputs return to reset values immediately; `WTOCNT_clk2 = 32'hFFFF_FFFF`; no ack toggle after release.
- Write WTOCNT: `wr_sel = 2`, `wr_data = 32'h0000_0100` with `WDEN = 0`, toggle `req_tgl` -> `WTOCNT_clk2 = 32'h100` at E3; `ack_tgl` toggles at E4 with `ack_err = 0`.
- Write WDEN = 1, then WTOCNT = 32'h50 -> `WDEN_clk2 = 1`; the WTOCNT write is dropped, `WTOCNT_clk2` stays 32'h100 and `ack_err = 1`.
- Write WDLIVE with data 1 -> `WDLIVE_clk2` is high for exactly one cycle; data 0 -> no pulse; both give `ack_err = 0`.
- `wr_sel = 3` -> no output change; `ack_err = 1`. A following valid WDEN = 0 write -> `ack_err = 0`.
- Early re-toggle during APPLY -> the second request is serviced after ACK and `ack_tgl` changes twice in total. With `WDT_SYNC3_EN` defined, rerun the WTOCNT write -> update at E4, ack at E5.
